// File: rtl/div_pkg.sv
// Shared types for the divider issue controller: FSM states, result record and default width.
package div_pkg;

    localparam int DIV_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DIV_DATA_W-1:0] q;
        logic [DIV_DATA_W-1:0] r;
        logic                  err;
    } div_result_t;

endpackage

// File: rtl/div_op_fifo.sv
// Request FIFO holding {dividend,divisor} pairs; full/empty/level derived from an occupancy counter.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int WIDTH = 2 * DIV_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (level_r == LVL_W'(DEPTH));
    assign empty_s   = (level_r == {LVL_W{1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Storage array write; entries are cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
        end
    end

    // Occupancy counter; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= {LVL_W{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer in front of the iterative divider: queues requests, launches one at a time, holds one result.
// Optional build macro DIV_BYPASS_INVALID_EN answers divide-by-zero and dividend<divisor without the divider.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_dividend,
    input  logic [DATA_W-1:0]        in_divisor,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     div_strt,
    output logic [DATA_W-1:0]        div_dividend,
    output logic [DATA_W-1:0]        div_divisor,
    input  logic                     div_idle,
    input  logic [DATA_W-1:0]        div_quotient,
    input  logic [DATA_W-1:0]        div_remainder,
    input  logic                     div_not_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_quotient,
    output logic [DATA_W-1:0]        out_remainder,
    output logic                     out_err
);

    div_state_e              state_r;
    div_state_e              state_nxt_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [2*DATA_W-1:0]     fifo_rdata_s;
    logic [DATA_W-1:0]       head_dividend_s;
    logic [DATA_W-1:0]       head_divisor_s;
    logic                    slot_free_s;
    logic                    pop_s;
    logic                    load_op_s;
    logic                    capture_s;
    logic                    bypass_s;
    logic                    byp_hit_s;
    logic [DATA_W-1:0]       byp_q_s;
    logic                    byp_err_s;
    logic                    div_strt_r;
    logic [DATA_W-1:0]       div_dividend_r;
    logic [DATA_W-1:0]       div_divisor_r;
    logic                    out_valid_r;
    logic [DATA_W-1:0]       out_quotient_r;
    logic [DATA_W-1:0]       out_remainder_r;
    logic                    out_err_r;

    div_op_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop_s),
        .wdata ({in_dividend, in_divisor}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    assign head_dividend_s = fifo_rdata_s[2*DATA_W-1:DATA_W];
    assign head_divisor_s  = fifo_rdata_s[DATA_W-1:0];
    assign slot_free_s     = !out_valid_r || out_ready;
    assign in_ready        = !fifo_full_s;

`ifdef DIV_BYPASS_INVALID_EN
    // Head entries the divider would reject or answer trivially are resolved locally.
    always_comb begin
        byp_err_s = (head_divisor_s == {DATA_W{1'b0}});
        byp_hit_s = byp_err_s || (head_dividend_s < head_divisor_s);
        byp_q_s   = byp_err_s ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    end
`else
    // Without the bypass every entry is sent to the divider.
    always_comb begin
        byp_err_s = 1'b0;
        byp_hit_s = 1'b0;
        byp_q_s   = {DATA_W{1'b0}};
    end
`endif

    // Issue FSM next-state and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_op_s   = 1'b0;
        capture_s   = 1'b0;
        bypass_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && slot_free_s) begin
                    if (byp_hit_s) begin
                        pop_s    = 1'b1;
                        bypass_s = 1'b1;
                    end else if (div_idle) begin
                        pop_s       = 1'b1;
                        load_op_s   = 1'b1;
                        state_nxt_s = LAUNCH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                state_nxt_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!div_idle) begin
                    state_nxt_s = WAIT_DONE;
                end else begin
                    state_nxt_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                // The slot was confirmed free at launch, so capture never overwrites a held result.
                if (div_idle) begin
                    capture_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register and the start pulse, which is high exactly while in LAUNCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            div_strt_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            div_strt_r <= (state_nxt_s == LAUNCH);
        end
    end

    // Operand registers stay put from one pop to the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_dividend_r <= {DATA_W{1'b0}};
            div_divisor_r  <= {DATA_W{1'b0}};
        end else if (load_op_s) begin
            div_dividend_r <= head_dividend_s;
            div_divisor_r  <= head_divisor_s;
        end else begin
            div_dividend_r <= div_dividend_r;
            div_divisor_r  <= div_divisor_r;
        end
    end

    // One-entry result register; data holds after a drain, only out_valid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r     <= 1'b0;
            out_quotient_r  <= {DATA_W{1'b0}};
            out_remainder_r <= {DATA_W{1'b0}};
            out_err_r       <= 1'b0;
        end else if (capture_s) begin
            out_valid_r     <= 1'b1;
            out_quotient_r  <= div_quotient;
            out_remainder_r <= div_remainder;
            out_err_r       <= div_not_valid;
        end else if (bypass_s) begin
            out_valid_r     <= 1'b1;
            out_quotient_r  <= byp_q_s;
            out_remainder_r <= head_dividend_s;
            out_err_r       <= byp_err_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r     <= 1'b0;
        end else begin
            out_valid_r     <= out_valid_r;
        end
    end

    assign div_strt      = div_strt_r;
    assign div_dividend  = div_dividend_r;
    assign div_divisor   = div_divisor_r;
    assign out_valid     = out_valid_r;
    assign out_quotient  = out_quotient_r;
    assign out_remainder = out_remainder_r;
    assign out_err       = out_err_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural multi-cycle divider; honours DIV_BYPASS_INVALID_EN.
module tb_div_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [7:0] in_divisor;
    logic [2:0] fifo_level;
    logic       div_strt;
    logic [7:0] div_dividend;
    logic [7:0] div_divisor;
    logic       div_idle;
    logic [7:0] div_quotient;
    logic [7:0] div_remainder;
    logic       div_not_valid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quotient;
    logic [7:0] out_remainder;
    logic       out_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int strt_cnt     = 0;
    int s0;
    logic [3:0] dv_cnt;
    logic       dv_hold;

    div_issue_ctrl #(.DATA_W(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .fifo_level    (fifo_level),
        .div_strt      (div_strt),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_idle      (div_idle),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_not_valid (div_not_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    // Behavioural divider: busy for four cycles after each start pulse.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_cnt        <= 4'd0;
            div_quotient  <= 8'd0;
            div_remainder <= 8'd0;
            div_not_valid <= 1'b0;
        end else if (div_strt) begin
            dv_cnt <= 4'd4;
            if (div_divisor == 8'd0) begin
                div_quotient  <= 8'hFF;
                div_remainder <= div_dividend;
                div_not_valid <= 1'b1;
            end else begin
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
                div_not_valid <= 1'b0;
            end
        end else if (dv_cnt != 4'd0) begin
            dv_cnt <= dv_cnt - 4'd1;
        end
    end

    assign div_idle = (dv_cnt == 4'd0) && !dv_hold;

    always @(posedge clk) begin
        if (div_strt) strt_cnt <= strt_cnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int q, input int r, input int e);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check_eq({tag, "_timeout"}, 0, 1);
        end else begin
            check_eq({tag, "_q"}, int'(out_quotient), q);
            check_eq({tag, "_r"}, int'(out_remainder), r);
            check_eq({tag, "_err"}, int'(out_err), e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_dividend = 8'd0;
        in_divisor  = 8'd0;
        out_ready   = 1'b1;
        dv_hold     = 1'b0;
        #12;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_err", int'(out_err), 0);
        check_eq("rst_out_q", int'(out_quotient), 0);
        check_eq("rst_div_strt", int'(div_strt), 0);
        check_eq("rst_level", int'(fifo_level), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_div_dividend", int'(div_dividend), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: single op 200/7
        s0 = strt_cnt;
        push(8'd200, 8'd7);
        wait_result("t1", 28, 4, 0);
        check_eq("t1_strt_cnt", strt_cnt - s0, 1);

        // 2: fill the FIFO while the divider is held busy
        s0 = strt_cnt;
        dv_hold   = 1'b1;
        out_ready = 1'b0;
        push(8'd100, 8'd9);
        push(8'd50, 8'd5);
        push(8'd255, 8'd16);
        push(8'd17, 8'd3);
        check_eq("t2_level_full", int'(fifo_level), 4);
        check_eq("t2_in_ready", int'(in_ready), 0);
        in_valid    = 1'b1;
        in_dividend = 8'd81;
        in_divisor  = 8'd8;
        @(negedge clk);
        check_eq("t2_no_push_when_full", int'(fifo_level), 4);
        check_eq("t2_no_launch_busy", strt_cnt - s0, 0);
        dv_hold = 1'b0;
        push(8'd81, 8'd8);
        wait_result("t2a", 11, 1, 0);
        wait_result("t2b", 10, 0, 0);
        wait_result("t2c", 15, 15, 0);
        wait_result("t2d", 5, 2, 0);
        wait_result("t2e", 10, 1, 0);
        check_eq("t2_strt_cnt", strt_cnt - s0, 5);

        // 3: backpressure holds the result and stalls further launches
        out_ready = 1'b0;
        push(8'd10, 8'd3);
        push(8'd20, 8'd6);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        s0 = strt_cnt;
        repeat (15) @(negedge clk);
        check_eq("t3_held_valid", int'(out_valid), 1);
        check_eq("t3_held_q", int'(out_quotient), 3);
        check_eq("t3_held_r", int'(out_remainder), 1);
        check_eq("t3_no_strt", strt_cnt - s0, 0);
        check_eq("t3_level", int'(fifo_level), 1);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_drained", int'(out_valid), 0);
        check_eq("t3_resume_strt", int'(div_strt), 1);
        wait_result("t3b", 3, 2, 0);

        // 4: divide by zero
        s0 = strt_cnt;
        push(8'd9, 8'd0);
        wait_result("t4", 255, 9, 1);
`ifdef DIV_BYPASS_INVALID_EN
        check_eq("t4_strt_cnt", strt_cnt - s0, 0);
`else
        check_eq("t4_strt_cnt", strt_cnt - s0, 1);
`endif

        // 5: dividend smaller than divisor
        s0 = strt_cnt;
        push(8'd3, 8'd10);
        wait_result("t5", 0, 3, 0);
`ifdef DIV_BYPASS_INVALID_EN
        check_eq("t5_strt_cnt", strt_cnt - s0, 0);
`else
        check_eq("t5_strt_cnt", strt_cnt - s0, 1);
`endif

        // 6: reset asserted while waiting for the divider
        push(8'd50, 8'd5);
        push(8'd60, 8'd6);
        for (int i = 0; i < 50 && div_idle; i++) @(negedge clk);
        @(negedge clk);
        check_eq("t6_pre_level", int'(fifo_level), 1);
        check_eq("t6_pre_busy", int'(div_idle), 0);
        rst = 1'b0;
        #1;
        check_eq("t6_out_valid", int'(out_valid), 0);
        check_eq("t6_level", int'(fifo_level), 0);
        check_eq("t6_in_ready", int'(in_ready), 1);
        check_eq("t6_div_dividend", int'(div_dividend), 0);
        @(negedge clk);
        rst = 1'b1;
        s0 = strt_cnt;
        repeat (10) @(negedge clk);
        check_eq("t6_no_result", int'(out_valid), 0);
        check_eq("t6_no_strt", strt_cnt - s0, 0);
        push(8'd77, 8'd7);
        wait_result("t6_recover", 11, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
